// File: rtl/oled_text_writer.sv
`default_nettype none
// ============================================================================
// oled_text_writer -- writes 8x8 glyphs or full-screen fills into the 1 KiB
// OLED frame-buffer RAM (address = page*128 + column, bit0 = top pixel).
// Revision: 1.0
// ============================================================================
module oled_text_writer #(
  parameter int CLEAR_WORDS = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_clear,
  input  logic [7:0] cmd_char,
  input  logic [2:0] cmd_row,
  input  logic [3:0] cmd_col,
  input  logic       cmd_inv,
  output logic [9:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic       wren,
  output logic [9:0] wraddress,
  output logic [7:0] wrdata,
  output logic       done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHAR  = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // In CHAR the counter holds (cycle number - 1); the k=7 write is in cycle 10.
  localparam logic [9:0] CHAR_LAST  = 10'd9;
  localparam logic [9:0] FETCH_LAST = 10'd6;
  localparam logic [9:0] CLR_LAST   = 10'(CLEAR_WORDS - 1);

  logic [1:0] state_q, state_d;
  logic [9:0] cnt_q, cnt_d;
  logic [6:0] char_q, char_d;
  logic [2:0] row_q, row_d;
  logic [3:0] col_q, col_d;
  logic       inv_q, inv_d;

  logic       cmd_ready_q, cmd_ready_d;
  logic       wren_q, wren_d;
  logic [9:0] wraddress_q, wraddress_d;
  logic [7:0] wrdata_q, wrdata_d;
  logic [9:0] rom_addr_q, rom_addr_d;
  logic       done_q, done_d;

  logic       accept;
  logic [9:0] cnt_inc;
  logic [2:0] wr_k;
  logic       char_fetch;
  logic       char_write;

  assign accept     = (state_q == S_IDLE) && cmd_valid && cmd_ready_q;
  assign cnt_inc    = cnt_q + 10'd1;
  // ROM data for byte k arrives when the counter is k+1, so the write index lags by one.
  assign wr_k       = cnt_q[2:0] - 3'd1;
  assign char_fetch = (cnt_q <= FETCH_LAST);
  assign char_write = (cnt_q >= 10'd1) && (cnt_q <= 10'd8);

  // State register and all datapath/output flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      char_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      inv_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      wren_q      <= 1'b0;
      wraddress_q <= '0;
      wrdata_q    <= '0;
      rom_addr_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      char_q      <= char_d;
      row_q       <= row_d;
      col_q       <= col_d;
      inv_q       <= inv_d;
      cmd_ready_q <= cmd_ready_d;
      wren_q      <= wren_d;
      wraddress_q <= wraddress_d;
      wrdata_q    <= wrdata_d;
      rom_addr_q  <= rom_addr_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = cmd_clear ? S_CLEAR : S_CHAR;
        end
      end
      S_CHAR: begin
        if (cnt_q == CHAR_LAST) begin
          state_d = S_DONE;
        end
      end
      S_CLEAR: begin
        if (cnt_q == CLR_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output and datapath logic
  always_comb begin
    cnt_d       = cnt_inc;
    char_d      = char_q;
    row_d       = row_q;
    col_d       = col_q;
    inv_d       = inv_q;
    cmd_ready_d = (state_d == S_IDLE);
    wren_d      = 1'b0;
    wraddress_d = wraddress_q;
    wrdata_d    = wrdata_q;
    rom_addr_d  = rom_addr_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          char_d = cmd_char[6:0];
          row_d  = cmd_row;
          col_d  = cmd_col;
          inv_d  = cmd_inv;
          if (cmd_clear) begin
            wren_d      = 1'b1;
            wraddress_d = '0;
            wrdata_d    = {8{cmd_inv}};
          end else begin
            rom_addr_d = {cmd_char[6:0], 3'd0};
          end
        end
      end
      S_CHAR: begin
        if (char_fetch) begin
          rom_addr_d = {char_q, cnt_inc[2:0]};
        end
        if (char_write) begin
          wren_d      = 1'b1;
          wraddress_d = {row_q, col_q, wr_k};
          wrdata_d    = rom_data ^ {8{inv_q}};
        end
        if (cnt_q == CHAR_LAST) begin
          done_d = 1'b1;
        end
      end
      S_CLEAR: begin
        if (cnt_q != CLR_LAST) begin
          wren_d      = 1'b1;
          wraddress_d = cnt_inc;
        end else begin
          done_d = 1'b1;
        end
      end
      S_DONE: begin
        cnt_d = '0;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  assign cmd_ready = cmd_ready_q;
  assign wren      = wren_q;
  assign wraddress = wraddress_q;
  assign wrdata    = wrdata_q;
  assign rom_addr  = rom_addr_q;
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_oled_text_writer.sv
`default_nettype none
// ============================================================================
// tb_oled_text_writer -- directed bench with a font-ROM model and RAM scoreboard.
// Revision: 1.0
// ============================================================================
module tb_oled_text_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_clear;
  logic [7:0] cmd_char;
  logic [2:0] cmd_row;
  logic [3:0] cmd_col;
  logic       cmd_inv;
  logic [9:0] rom_addr;
  logic [7:0] rom_data;
  logic       wren;
  logic [9:0] wraddress;
  logic [7:0] wrdata;
  logic       done;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [1024];
  int         wr_count   = 0;
  int         done_count = 0;

  oled_text_writer #(.CLEAR_WORDS(1024)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_clear (cmd_clear),
    .cmd_char  (cmd_char),
    .cmd_row   (cmd_row),
    .cmd_col   (cmd_col),
    .cmd_inv   (cmd_inv),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .wren      (wren),
    .wraddress (wraddress),
    .wrdata    (wrdata),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Font ROM model: byte k of every glyph is 0x10 + k, one cycle of latency.
  always @(posedge clk) begin
    rom_data <= 8'h10 + {5'd0, rom_addr[2:0]};
  end

  always @(posedge clk) begin
    if (wren) begin
      mem[wraddress] <= wrdata;
      wr_count       <= wr_count + 1;
    end
    if (done) begin
      done_count <= done_count + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 32) begin
      tick();
      n++;
    end
    if (!cmd_ready) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic set_cmd(input logic clr, input logic [7:0] ch, input logic [2:0] row,
                         input logic [3:0] col, input logic inv);
    cmd_clear = clr;
    cmd_char  = ch;
    cmd_row   = row;
    cmd_col   = col;
    cmd_inv   = inv;
  endtask

  // Called in cycle 1 after acceptance; returns in cycle 11.
  task automatic check_char(input logic [9:0] rbase, input logic [9:0] wbase,
                            input logic inv, input bit scramble);
    logic [18:0] exp_w;
    for (int n = 1; n <= 11; n++) begin
      if (n <= 8) chk("rom_addr", 32'(rom_addr), 32'(rbase + 10'(n - 1)));
      if (n >= 3 && n <= 10) begin
        exp_w = {1'b1, wbase + 10'(n - 3), (8'h10 + 8'(n - 3)) ^ {8{inv}}};
        chk("char_write", 32'({wren, wraddress, wrdata}), 32'(exp_w));
      end else begin
        chk("char_wren_off", 32'(wren), 32'd0);
      end
      chk("char_done", 32'(done), (n == 11) ? 32'd1 : 32'd0);
      chk("char_busy", 32'(cmd_ready), 32'd0);
      if (scramble) begin
        cmd_clear = 1'($urandom);
        cmd_char  = 8'($urandom);
        cmd_row   = 3'($urandom);
        cmd_col   = 4'($urandom);
        cmd_inv   = 1'($urandom);
      end
      if (n < 11) tick();
    end
  endtask

  task automatic run_char(input logic [7:0] ch, input logic [2:0] row,
                          input logic [3:0] col, input logic inv);
    int w0;
    logic [9:0] wb;
    wait_ready();
    set_cmd(1'b0, ch, row, col, inv);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    w0 = wr_count;
    wb = {row, col, 3'd0};
    check_char({ch[6:0], 3'd0}, wb, inv, 1'b0);
    tick();
    chk("char_ready_again", 32'(cmd_ready), 32'd1);
    chk("char_write_count", 32'(wr_count - w0), 32'd8);
    for (int k = 0; k < 8; k++) begin
      chk("char_mem", 32'(mem[wb + 10'(k)]), 32'((8'h10 + 8'(k)) ^ {8{inv}}));
    end
  endtask

  task automatic run_clear(input logic inv);
    int w0;
    int bad;
    wait_ready();
    set_cmd(1'b1, 8'h00, 3'd0, 4'd0, inv);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    w0 = wr_count;
    for (int n = 1; n <= 1024; n++) begin
      chk("clear_write", 32'({wren, wraddress, wrdata}),
          32'({1'b1, 10'(n - 1), {8{inv}}}));
      tick();
    end
    chk("clear_done", 32'(done), 32'd1);
    chk("clear_wren_off", 32'(wren), 32'd0);
    tick();
    chk("clear_done_pulse", 32'(done), 32'd0);
    chk("clear_ready_again", 32'(cmd_ready), 32'd1);
    chk("clear_write_count", 32'(wr_count - w0), 32'd1024);
    bad = 0;
    for (int a = 0; a < 1024; a++) begin
      if (mem[a] !== {8{inv}}) bad++;
    end
    chk("clear_mem", 32'(bad), 32'd0);
  endtask

  initial begin
    int w0;
    int d0;
    rst       = 1'b1;
    cmd_valid = 1'b1;
    set_cmd(1'b0, 8'h41, 3'd0, 4'd0, 1'b0);

    // Reset held three cycles with a command pending
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_outputs", 32'({cmd_ready, wren, wraddress, wrdata, rom_addr, done}), 32'd0);
    end
    chk("rst_no_write", 32'(wr_count), 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_wren", 32'(wren), 32'd0);

    // 'A' accepted at the next edge
    tick();
    cmd_valid = 1'b0;
    w0 = wr_count;
    check_char(10'h208, 10'd0, 1'b0, 1'b0);
    tick();
    chk("a_ready_again", 32'(cmd_ready), 32'd1);
    chk("a_write_count", 32'(wr_count - w0), 32'd8);
    for (int k = 0; k < 8; k++) chk("a_mem", 32'(mem[k]), 32'(8'h10 + 8'(k)));

    run_clear(1'b0);

    // Bit7 ignored, bottom-right cell, inverted
    run_char(8'hC1, 3'd7, 4'd15, 1'b1);

    run_clear(1'b1);

    // cmd_valid held with changing fields: next accept only at the edge ending cycle 12
    wait_ready();
    set_cmd(1'b0, 8'h41, 3'd1, 4'd2, 1'b0);
    cmd_valid = 1'b1;
    tick();
    check_char(10'h208, 10'd144, 1'b0, 1'b1);
    set_cmd(1'b1, 8'h7F, 3'd6, 4'd9, 1'b1);
    tick();
    chk("hold_ready_c12", 32'(cmd_ready), 32'd1);
    set_cmd(1'b0, 8'h42, 3'd3, 4'd5, 1'b0);
    tick();
    cmd_valid = 1'b0;
    check_char(10'h210, 10'd424, 1'b0, 1'b0);
    tick();
    chk("hold_ready_again", 32'(cmd_ready), 32'd1);

    // Reset in cycle 5 of a character
    run_clear(1'b0);
    wait_ready();
    set_cmd(1'b0, 8'h41, 3'd0, 4'd0, 1'b1);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    w0 = wr_count;
    d0 = done_count;
    for (int i = 0; i < 4; i++) tick();
    chk("abort_c5_write", 32'({wren, wraddress, wrdata}), 32'({1'b1, 10'd2, 8'hED}));
    rst = 1'b1;
    tick();
    chk("abort_wren_off", 32'(wren), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    chk("abort_regs", 32'({wraddress, wrdata, rom_addr}), 32'd0);
    chk("abort_write_count", 32'(wr_count - w0), 32'd3);
    chk("abort_no_done", 32'(done_count - d0), 32'd0);
    chk("abort_mem0", 32'(mem[0]), 32'hEF);
    chk("abort_mem1", 32'(mem[1]), 32'hEE);
    chk("abort_mem2", 32'(mem[2]), 32'hED);
    for (int k = 3; k < 8; k++) chk("abort_untouched", 32'(mem[k]), 32'h00);

    run_char(8'h30, 3'd0, 4'd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
